// File: rtl/data_mem_if.sv
// CPU data-memory port: request/address/data from the CPU, read data and stall back.
// Latency: n/a (wiring only).
// Backpressure: BUSYWAIT from the memory stalls the CPU while an access is in flight.
interface data_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              READMEM;
  logic              WRITEMEM;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  // CPU side
  modport master (
    output READMEM, WRITEMEM, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  // Memory side
  modport slave (
    input  READMEM, WRITEMEM, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/data_mem.sv
// Byte-addressable data memory answering the CPU READMEM/WRITEMEM handshake.
// Latency: LATENCY edges from acceptance to array/READDATA update, then one ACK cycle.
// Backpressure: BUSYWAIT is high from request assertion until the ACK cycle; requests in ACK are ignored.
module data_mem #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 5   // 1..15
) (
  input  logic         CLK,
  input  logic         RESET,  // asynchronous, active-low
  data_mem_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_rd;     // 1 = read, 0 = write
  logic [DATA_W-1:0] rd_q;
  logic              busy_c;
  logic              req;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req = bus.READMEM | bus.WRITEMEM;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and stall; stall is combinational in IDLE so the CPU sees it before the accepting edge
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        busy_c = 1'b1;
        if (cnt == 4'd0) state_nxt = ACK;
      end
      ACK: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset must silence the stall immediately, independent of any request still held high
  assign bus.BUSYWAIT = RESET & busy_c;
  assign bus.READDATA = rd_q;

  // Request latching, latency countdown and the final array/read-data update
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_rd   <= 1'b0;
      rd_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= bus.ADDRESS;
            lat_data <= bus.WRITEDATA;
            lat_rd   <= bus.READMEM;   // simultaneous read+write resolves to a read
            cnt      <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (lat_rd) rd_q <= mem[lat_addr];
            else        mem[lat_addr] <= lat_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic CLK;
  logic RESET;
  int   cyc;
  int   tests;
  int   fails;

  data_mem_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
  data_mem_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

  data_mem #(.DATA_W(8), .ADDR_W(8), .LATENCY(5)) u_mem5 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus0.slave)
  );

  data_mem #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) u_mem1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (sel == 0) begin
      bus0.READMEM = rd; bus0.WRITEMEM = wr; bus0.ADDRESS = a; bus0.WRITEDATA = d;
    end else begin
      bus1.READMEM = rd; bus1.WRITEMEM = wr; bus1.ADDRESS = a; bus1.WRITEDATA = d;
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.BUSYWAIT : bus1.BUSYWAIT;
  endfunction

  function automatic logic [7:0] get_rd(input int sel);
    return (sel == 0) ? bus0.READDATA : bus1.READDATA;
  endfunction

  // One CPU access: assert request, hold it while BUSYWAIT is high, drop it in the ACK cycle.
  // Returns number of BUSY cycles after acceptance, acceptance cycle, and READDATA seen in ACK.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d, input bit scramble,
                        output int busy_n, output int acc_cyc, output logic [7:0] rdata);
    bit done;
    @(negedge CLK);
    drive(sel, rd, wr, a, d);
    #1;
    check("comb_busywait", int'(get_busy(sel)), 1);
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    busy_n  = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (get_busy(sel)) begin
        busy_n++;
        if (scramble) drive(sel, rd, wr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: BUSYWAIT still high after 40 cycles, required low");
    end
    rdata = get_rd(sel);
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  int         busy_n, acc1, acc2;
  logic [7:0] rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;

    //           rd    wr    addr   wdata  exp READDATA in ACK
    vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00};  // write leaves READDATA at reset value
    vecs[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5};  // round trip
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h11, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h22, 8'hA5};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h11};  // lowest byte
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h22};  // highest byte
    vecs[6] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00};  // never written
    vecs[7] = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[8] = '{1'b1, 1'b1, 8'h10, 8'hFF, 8'h5A};  // both asserted -> read
    vecs[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};  // array not overwritten

    // Reset held with a request pending
    RESET = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", int'(bus0.BUSYWAIT), 0);
    check("reset_readdata", int'(bus0.READDATA), 0);
    RESET = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("idle_busywait", int'(bus0.BUSYWAIT), 0);
    end

    // Directed vector table on the LATENCY=5 instance
    for (int i = 0; i < 10; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, busy_n, acc1, rdata);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 5);
      check($sformatf("vec%0d_readdata", i), int'(rdata), int'(vecs[i].exp_rd));
      @(negedge CLK);
      check($sformatf("vec%0d_idle_after_ack", i), int'(bus0.BUSYWAIT), 0);
    end

    // Reset in the middle of a write: abort, no array update, READDATA cleared
    @(negedge CLK);
    drive(0, 1'b0, 1'b1, 8'h20, 8'h77);
    @(posedge CLK);              // accepted, counter = 4
    repeat (2) @(posedge CLK);   // counter = 2
    @(negedge CLK);
    check("midwr_busy_before_reset", int'(bus0.BUSYWAIT), 1);
    RESET = 1'b0;
    #1;
    check("midwr_busywait_reset", int'(bus0.BUSYWAIT), 0);
    check("midwr_readdata_reset", int'(bus0.READDATA), 0);
    @(negedge CLK);
    RESET = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h20, 8'h77);
    access(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, busy_n, acc1, rdata);
    check("midwr_read_aborted", int'(rdata), 0);
    access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, busy_n, acc1, rdata);
    check("reset_cleared_array", int'(rdata), 0);

    // Back-to-back reads, ADDRESS/WRITEDATA scrambled during BUSY
    access(0, 1'b0, 1'b1, 8'h05, 8'h42, 1'b0, busy_n, acc1, rdata);
    access(0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, busy_n, acc1, rdata);
    check("b2b_first_readdata", int'(rdata), 8'h42);
    access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, busy_n, acc2, rdata);
    check("b2b_spacing_lat5", acc2 - acc1, 7);
    check("b2b_second_readdata", int'(rdata), 0);

    // LATENCY = 1 instance
    access(1, 1'b0, 1'b1, 8'h07, 8'h9C, 1'b0, busy_n, acc1, rdata);
    check("lat1_write_busy_cycles", busy_n, 1);
    access(1, 1'b1, 1'b0, 8'h07, 8'h00, 1'b1, busy_n, acc1, rdata);
    check("lat1_read_busy_cycles", busy_n, 1);
    check("lat1_readdata", int'(rdata), 8'h9C);
    access(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, busy_n, acc2, rdata);
    check("b2b_spacing_lat1", acc2 - acc1, 3);
    check("lat1_readdata_ff", int'(rdata), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory that serves the CPU's data-memory port. It is the responder end of the READMEM/WRITEMEM/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake. Each accepted access is held for a programmable number of cycles with BUSYWAIT asserted, which stalls the CPU's PC and register write. The access then completes with a one-cycle acknowledge window. It sits beside the CPU at top level, wired directly to the CPU's memory port.

## Interface
- DATA_W, 8: data width in bits
- ADDR_W, 8: address width; depth is 2^ADDR_W bytes (256)
- LATENCY, 5: cycles spent in BUSY per access; legal range 1..15
- CLK  input  1  single clock; all state updates on rising edge
- RESET  input  1  reset, asynchronous, active-low (0 = reset)
- READMEM  input  1  read request from CPU, level-held until BUSYWAIT falls
- WRITEMEM  input  1  write request from CPU, level-held until BUSYWAIT falls
- ADDRESS  input  ADDR_W  byte address, sampled at request acceptance
- WRITEDATA  input  DATA_W  write data, sampled at request acceptance
- READDATA  output  DATA_W  registered read data
- BUSYWAIT  output  1  stall to CPU

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus latched address, latched data, latched op, 4-bit down-counter, and a 2-bit state.
- States are IDLE, BUSY and ACK.
- IDLE
  - BUSYWAIT = READMEM | WRITEMEM, combinational, so the stall is visible before the next edge.
  - On an edge with a request: latch ADDRESS, WRITEDATA and op; load counter = LATENCY-1; go to BUSY.
- Both READMEM and WRITEMEM asserted: treated as a read. No array write occurs.
- BUSY
  - BUSYWAIT = 1, registered-state driven.
  - Counter decrements each edge.
  - On the edge where counter == 0: a read loads READDATA <= mem[latched addr]; a write does mem[latched addr] <= latched data. Then go to ACK.
- ACK
  - BUSYWAIT = 0 and READDATA holds its value.
  - Requests seen in ACK are ignored; the CPU drops READMEM/WRITEMEM on the BUSYWAIT fall.
  - Next edge goes unconditionally to IDLE.
- Changes to ADDRESS or WRITEDATA during BUSY or ACK have no effect.
- A write leaves READDATA unchanged.
- Address arithmetic is plain indexing, with no wrap logic; address 0xFF is the last byte.

## Timing
- Reset (RESET = 0, async):
  - State goes to IDLE, counter to 0, READDATA to 0.
  - BUSYWAIT is forced to 0 regardless of requests.
  - All array bytes are cleared to 0.
- Reset mid-access aborts it: no array write, READDATA = 0. After release, the block is in IDLE and samples the next request normally.
- Access latency: request accepted at edge N; BUSYWAIT is high from request assertion through edge N+LATENCY; data/array update at edge N+LATENCY; BUSYWAIT low during ACK; IDLE at edge N+LATENCY+1.
- READDATA is valid from edge N+LATENCY until the next completed read or reset. The CPU register file captures it at edge N+LATENCY+1.
- Back-to-back accesses: a request newly asserted after ACK is accepted at the first edge in IDLE. The minimum spacing between acceptances is LATENCY+2 edges.
- With LATENCY = 1 there is a single BUSY cycle; the update happens at the edge after acceptance.
- A request deasserted early during BUSY still completes; the op is latched.

## Test plan
- Reset then idle: hold RESET = 0 with READMEM = 1 → BUSYWAIT = 0 and READDATA = 0x00. Release with no request → BUSYWAIT stays 0.
- Write/read round trip: WRITEMEM = 1, ADDRESS = 0x3C, WRITEDATA = 0xA5.
  - BUSYWAIT is high for exactly 5 edges, then low for 1 cycle.
  - A following READMEM at 0x3C gives READDATA = 0xA5 exactly 5 edges after acceptance.
- Address boundaries: write 0x11 to 0x00 and 0x22 to 0xFF, then read both → 0x11 and 0x22. Read 0x80 (never written) → 0x00.
- Both requests asserted: READMEM = WRITEMEM = 1, ADDRESS = 0x10 (holding 0x5A), WRITEDATA = 0xFF → READDATA = 0x5A and mem[0x10] is still 0x5A.
- Reset mid-write: start a write of 0x77 to 0x20, pull RESET low at BUSY count 2 → BUSYWAIT goes 0 immediately. After release, a read of 0x20 returns 0x00.
- Back-to-back and latency variants:
  - Two reads, the second asserted right after BUSYWAIT falls → acceptances are 7 edges apart and ADDRESS changes during BUSY are ignored.
  - Repeat with LATENCY = 1 → acceptances are 3 edges apart.
